uart_rx: RTL and testbench
==========================

# uart_rx

16x-oversampling UART receiver that turns the serial line into parallel bytes. It is the receive-side consumer of the `sample_tick` strobe from the baud-rate generator: one `sample_tick` pulse is one oversample slot, and `OVERSAMPLE` slots make one bit time. The block synchronises the asynchronous `rx` line, validates the start bit, and shifts in the data bits LSB first. It checks the stop bit and, when configured, the parity bit, then presents the byte with a one-cycle valid pulse and error flags.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5–8.
- `OVERSAMPLE`, default 16: `sample_tick` pulses per bit time; must be even and ≥ 8.
- `sys_clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset: one clock, synchronous, active-low (`rst`=0 resets on the next `sys_clk` edge).
- `sample_tick`  in  1  single-cycle oversample strobe from the baud-rate generator.
- `rx`  in  1  asynchronous serial input; idles high.
- `rx_data`  out  DATA_BITS  last received byte; holds its value until the next frame completes.
- `rx_valid`  out  1  one-cycle pulse when a frame completes.
- `frame_err`  out  1  stop bit sampled low; qualified by `rx_valid`.
- `parity_err`  out  1  parity mismatch; qualified by `rx_valid`. Tied 0 when parity is compiled out.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Input synchroniser.** `rx` passes through a 2-flop synchroniser to give `rx_s`. Both flops reset to 1.
- **Counters.**
  - `tick_cnt`: width clog2(OVERSAMPLE). Advances only on `sample_tick`.
  - `bit_cnt`: width clog2(DATA_BITS+1).
- **States:** IDLE, START, DATA, PARITY (only with the macro), STOP.
- **IDLE.**
  - An `armed` flag sets when `rx_s`=1.
  - If `armed` and `rx_s`=0: go to START, clear `tick_cnt`, clear `armed`.
- **START.**
  - On `sample_tick`, when `tick_cnt`=OVERSAMPLE/2−1:
    - `rx_s`=0: go to DATA, clear `tick_cnt` and `bit_cnt`.
    - `rx_s`=1: treat as a glitch and return to IDLE. No `rx_valid`.
  - On other `sample_tick`s, `tick_cnt`++.
- **DATA.**
  - On `sample_tick`, when `tick_cnt`=OVERSAMPLE−1: `shift <= {rx_s, shift[DATA_BITS-1:1]}` (LSB first), `bit_cnt`++, clear `tick_cnt`.
  - After `bit_cnt` reaches DATA_BITS, go to PARITY, or to STOP when parity is compiled out.
- **PARITY.** At the mid-bit sample (`tick_cnt`=OVERSAMPLE−1), capture the parity bit. Then go to STOP.
- **STOP.** At the mid-bit sample (`tick_cnt`=OVERSAMPLE−1), register these values and return to IDLE:
  - `rx_data <= shift`
  - `frame_err <= ~rx_s`
  - `parity_err`
  - `rx_valid <= 1`
- **Errored frames.** A frame with `frame_err` still delivers `rx_valid` and `rx_data`.
- **Break condition.** The line held low never re-arms IDLE, so no further frames are produced until `rx_s` returns high.
- **`sample_tick` inside a state.** Ignored at any `tick_cnt` value other than the decision points above, apart from advancing `tick_cnt`.
- **Reset mid-frame.**
  - State, counters, `shift` and `armed` are cleared; state goes to IDLE.
  - Outputs take their reset values.
  - The partial frame is discarded with no `rx_valid`.

## Timing
- Output reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0.
- Start detection: 2 `sys_clk` of synchroniser latency, plus 1 cycle into START.
- Data sample points: the first sample is at OVERSAMPLE/2 ticks into the start bit. Each later sample is OVERSAMPLE ticks after the previous one.
- `rx_valid` goes high on the `sys_clk` edge that consumes the stop-bit `sample_tick`, and is high for exactly 1 cycle.
- `frame_err` and `parity_err` are valid in that same cycle and hold until the next frame completes.
- Back-to-back frames: the next start bit may begin immediately after the stop bit. IDLE must accept it because `rx_s`=1 during the stop bit sets `armed`.
- `busy` rises 1 cycle after the falling edge is seen in `rx_s`. It falls on the same edge that raises `rx_valid`.

## Configuration
- `UART_RX_PARITY_EN`, defined:
  - The PARITY state is present; parity is even.
  - `parity_err <= ^{shift, parity_bit}`.
  - A frame is 1 start + DATA_BITS + 1 parity + 1 stop bits.
- Undefined:
  - No PARITY state; a frame is 1 start + DATA_BITS + 1 stop bits.
  - `parity_err` is constant 0.

## Test plan
- **Clean byte.** `sample_tick` every 4 clocks; send 0xA5, 8N1 -> exactly one `rx_valid` pulse with `rx_data`=0xA5, `frame_err`=0, `busy`=0 afterwards.
- **Start glitch.** Drive `rx` low for 4 ticks, then high -> no `rx_valid`, state back in IDLE, `busy`=0. A following 0x3C frame is received correctly.
- **Framing error and break.**
  - Send 0x3C with the stop bit 0 -> `rx_valid` with `rx_data`=0x3C and `frame_err`=1.
  - Hold `rx` low for 40 bit times -> no further `rx_valid`.
  - Release `rx` high, then send 0x81 -> 0x81 received with `frame_err`=0.
- **Back-to-back frames.** Send 0x00 then 0xFF with no idle gap -> two `rx_valid` pulses, exactly 10 bit times apart, with the correct data.
- **Reset mid-frame.** Drive `rst`=0 for 1 cycle after the 3rd data bit -> all outputs 0, no `rx_valid`. A following 0x5A frame is received correctly.
- **Parity (with `UART_RX_PARITY_EN`).**
  - Send 0x01 with parity bit 0 -> `parity_err`=1.
  - Send 0x01 with parity bit 1 -> `parity_err`=0.

Source files
------------

// File: rtl/uart_rx_if.sv
// Signal bundle between a UART receiver and its consumer.
// The receiver takes the slave modport; the consumer or bench drives the line and tick through master.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 sample_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    output sample_tick, rx,
    input  rx_data, rx_valid, frame_err, parity_err, busy
  );

  modport slave (
    input  sample_tick, rx,
    output rx_data, rx_valid, frame_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit validation, LSB-first data, stop check, one-cycle valid pulse.
// Even parity is compiled in by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic      sys_clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit_q, parity_bit_d;
  logic                 parity_err_q, parity_err_d;
`endif
  logic                 rx_s;

  assign rx_s = sync_q[1];

  // NOTE: every variable gets its hold/default value first, so no path through the case leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], bus.rx};
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
    parity_err_d = parity_err_q;
`endif

    case (state_q)
      IDLE: begin
        // A low line only counts as a start once it has been seen high, so a held break never re-triggers.
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d    = START;
          tick_cnt_d = '0;
          armed_d    = 1'b0;
        end
      end

      START: if (bus.sample_tick) begin
        if (tick_cnt_q == HALF_M1) begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = rx_s ? IDLE : DATA;
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end

      DATA: if (bus.sample_tick) begin
        if (tick_cnt_q == FULL_M1) begin
          shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d  = bit_cnt_q + BW'(1);
          tick_cnt_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: if (bus.sample_tick) begin
        if (tick_cnt_q == FULL_M1) begin
          parity_bit_d = rx_s;
          tick_cnt_d   = '0;
          state_d      = STOP;
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
`endif

      STOP: if (bus.sample_tick) begin
        if (tick_cnt_q == FULL_M1) begin
          rx_data_d   = shift_q;
          frame_err_d = ~rx_s;
          rx_valid_d  = 1'b1;
          tick_cnt_d  = '0;
          state_d     = IDLE;
`ifdef UART_RX_PARITY_EN
          parity_err_d = ^{shift_q, parity_bit_q};
`endif
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples the pre-edge values computed above.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;  // idle-high line: resetting to 1 avoids a false start edge
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= parity_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level expectation queue plus held-output model checked every cycle.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int TICK_DIV   = 4;
  localparam int BIT_CYC    = OVERSAMPLE * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 3;
`else
  localparam int FRAME_BITS = DATA_BITS + 2;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } frame_t;

  logic sys_clk = 1'b0;
  logic rst;

  uart_rx_if #(.DATA_BITS(DATA_BITS)) bus ();

  uart_rx #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int          errors = 0;
  int          checks = 0;
  int          valid_cnt = 0;
  int unsigned cyc = 0;
  int unsigned valid_cyc[$];
  frame_t      exp_q[$];
  logic [7:0]  m_data = 8'h00;
  logic        m_ferr = 1'b0;
  logic        m_perr = 1'b0;
  logic        prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  // Oversample strobe: one cycle high every TICK_DIV clocks.
  initial begin
    bus.sample_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(posedge sys_clk);
      #1 bus.sample_tick = 1'b1;
      @(posedge sys_clk);
      #1 bus.sample_tick = 1'b0;
    end
  end

  // Compare process: every out-of-reset cycle the held outputs must match the last completed frame.
  always @(negedge sys_clk) begin
    cyc++;
    if (rst === 1'b1) begin
      if (prev_valid)
        check("valid_pulse_width", bus.rx_valid, 1'b0);
      if (bus.rx_valid === 1'b1) begin
        valid_cnt++;
        valid_cyc.push_back(cyc);
        check("valid_expected", exp_q.size() > 0, 1'b1);
        check("busy_at_valid", bus.busy, 1'b0);
        if (exp_q.size() > 0) begin
          frame_t f;
          f = exp_q.pop_front();
          m_data = f.data;
          m_ferr = f.ferr;
          m_perr = f.perr;
        end
      end
      check("rx_data", bus.rx_data, m_data);
      check("frame_err", bus.frame_err, m_ferr);
      check("parity_err", bus.parity_err, m_perr);
      prev_valid = bus.rx_valid;
    end
  end

  task automatic send_bit(input logic b);
    bus.rx = b;
    repeat (BIT_CYC) @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int bits);
    bus.rx = 1'b1;
    repeat (bits * BIT_CYC) @(posedge sys_clk);
    #1;
  endtask

  // Expectation is queued just before the stop bit, so an early pulse is caught as unexpected.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit);
    frame_t f;
    send_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_bit);
    f.perr = ^{data, par_bit};
`else
    f.perr = 1'b0;
`endif
    f.data = data;
    f.ferr = ~stop_bit;
    exp_q.push_back(f);
    send_bit(stop_bit);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge sys_clk);
    #1;
    exp_q.delete();
    m_data = 8'h00;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    prev_valid = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc;
    int unsigned gap;
    rst    = 1'b0;
    bus.rx = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 rst = 1'b1;
    @(negedge sys_clk);
    check("reset_rx_data", bus.rx_data, 8'h00);
    check("reset_rx_valid", bus.rx_valid, 1'b0);
    check("reset_frame_err", bus.frame_err, 1'b0);
    check("reset_parity_err", bus.parity_err, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    @(posedge sys_clk);
    #1;
    idle(1);

    // Clean byte
    vc = valid_cnt;
    send_frame(8'hA5, 1'b1, even_par(8'hA5));
    idle(1);
    check("clean_count", valid_cnt - vc, 1);
    check("clean_data", bus.rx_data, 8'hA5);
    check("clean_ferr", bus.frame_err, 1'b0);
    check("clean_busy", bus.busy, 1'b0);

    // Start glitch, with busy-rise latency pinned
    vc = valid_cnt;
    bus.rx = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("busy_before_start", bus.busy, 1'b0);
    @(negedge sys_clk);
    check("busy_after_start", bus.busy, 1'b1);
    repeat (12) @(posedge sys_clk);
    #1;
    idle(2);
    check("glitch_count", valid_cnt - vc, 0);
    check("glitch_busy", bus.busy, 1'b0);
    send_frame(8'h3C, 1'b1, even_par(8'h3C));
    idle(1);
    check("post_glitch_count", valid_cnt - vc, 1);
    check("post_glitch_data", bus.rx_data, 8'h3C);

    // Framing error followed by a 40-bit break
    vc = valid_cnt;
    send_frame(8'h3C, 1'b0, even_par(8'h3C));
    repeat (40 * BIT_CYC) @(posedge sys_clk);
    #1;
    check("break_count", valid_cnt - vc, 1);
    check("ferr_data", bus.rx_data, 8'h3C);
    check("ferr_flag", bus.frame_err, 1'b1);
    check("break_busy", bus.busy, 1'b0);
    idle(2);
    send_frame(8'h81, 1'b1, even_par(8'h81));
    idle(1);
    check("after_break_count", valid_cnt - vc, 2);
    check("after_break_data", bus.rx_data, 8'h81);
    check("after_break_ferr", bus.frame_err, 1'b0);

    // Back-to-back frames
    vc = valid_cnt;
    send_frame(8'h00, 1'b1, even_par(8'h00));
    send_frame(8'hFF, 1'b1, even_par(8'hFF));
    idle(1);
    check("b2b_count", valid_cnt - vc, 2);
    check("b2b_data", bus.rx_data, 8'hFF);
    if (valid_cyc.size() >= 2) begin
      gap = valid_cyc[valid_cyc.size()-1] - valid_cyc[valid_cyc.size()-2];
      check("b2b_gap", gap, FRAME_BITS * BIT_CYC);
    end

    // Reset after the third data bit
    vc = valid_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    do_reset();
    @(negedge sys_clk);
    check("mid_reset_rx_data", bus.rx_data, 8'h00);
    check("mid_reset_rx_valid", bus.rx_valid, 1'b0);
    check("mid_reset_frame_err", bus.frame_err, 1'b0);
    check("mid_reset_busy", bus.busy, 1'b0);
    @(posedge sys_clk);
    #1;
    idle(12);
    check("mid_reset_count", valid_cnt - vc, 0);
    send_frame(8'h5A, 1'b1, even_par(8'h5A));
    idle(1);
    check("post_reset_count", valid_cnt - vc, 1);
    check("post_reset_data", bus.rx_data, 8'h5A);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b0);
    idle(1);
    check("parity_bad", bus.parity_err, 1'b1);
    send_frame(8'h01, 1'b1, 1'b1);
    idle(1);
    check("parity_good", bus.parity_err, 1'b0);
`endif

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
